// File: rtl/pixel_sink.sv
// Pixel sink: buffers plot requests in a small FIFO, converts (x, y) to a linear
// framebuffer address and drives the video memory write port; also runs full-screen clears.
module pixel_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        plot,
  input  logic [8:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [2:0]  colour_in,
  output logic        ready,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic        clear_done,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NPIX = SCREEN_W * SCREEN_H;

  typedef enum logic [1:0] {STREAM, DRAIN, CLEAR} state_t;

  state_t      state_reg;
  logic [19:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [16:0] clr_cnt_reg;
  logic [2:0]  clr_colour_reg;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [19:0] head;
  logic [8:0]  head_x;
  logic [7:0]  head_y;
  logic [2:0]  head_c;
  logic        head_in_range;
  logic [16:0] head_addr;
  logic        clr_last;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign ready = (state_reg == STREAM) && !fifo_full;
  assign push  = plot && ready;
  assign pop   = !fifo_empty;
  assign busy  = !fifo_empty || mem_we || (state_reg != STREAM);

  assign head          = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign head_x        = head[19:11];
  assign head_y        = head[10:3];
  assign head_c        = head[2:0];
  assign head_in_range = (int'(head_x) < SCREEN_W) && (int'(head_y) < SCREEN_H);
  // y*320 as two shifts; the sum stays within 17 bits for any legal coordinate.
  assign head_addr     = ({9'd0, head_y} << 8) + ({9'd0, head_y} << 6) + {8'd0, head_x};
  assign clr_last      = (clr_cnt_reg == 17'(NPIX - 1));

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {x_in, y_in, colour_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= STREAM;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      clr_cnt_reg    <= '0;
      clr_colour_reg <= '0;
      mem_addr       <= '0;
      mem_data       <= '0;
      mem_we         <= 1'b0;
      clear_done     <= 1'b0;
      drop_count     <= '0;
    end else begin
      mem_we     <= 1'b0;
      clear_done <= 1'b0;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end

      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (head_in_range) begin
          mem_we   <= 1'b1;
          mem_addr <= head_addr;
          mem_data <= head_c;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end

      case (state_reg)
        STREAM: begin
          // A plot accepted alongside clear_req is already queued, so it drains first.
          if (clear_req) begin
            clr_colour_reg <= clear_colour;
            state_reg      <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            clr_cnt_reg <= '0;
            state_reg   <= CLEAR;
          end
        end
        CLEAR: begin
          mem_we      <= 1'b1;
          mem_addr    <= clr_cnt_reg;
          mem_data    <= clr_colour_reg;
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_last) begin
            clear_done <= 1'b1;
            state_reg  <= STREAM;
          end
        end
        default: state_reg <= STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: stimulus pushes expected memory writes into a queue,
// a negedge monitor pops and compares every mem_we cycle.
module tb_pixel_sink;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        plot = 1'b0;
  logic [8:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic [2:0]  colour_in = '0;
  logic        ready;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        clear_done;
  logic        busy;
  logic [7:0]  drop_count;

  pixel_sink #(.FIFO_DEPTH(4), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .plot         (plot),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .ready        (ready),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .clear_done   (clear_done),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [16:0] addr;
    logic [2:0]  data;
    logic        done;
    logic        is_clr;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [16:0] addr, input logic [2:0] data,
                          input logic done, input logic is_clr);
    exp_t e;
    e.addr = addr; e.data = data; e.done = done; e.is_clr = is_clr;
    exp_q.push_back(e);
  endtask

  // Expected writes for a whole-screen clear, in address order.
  task automatic push_clear(input logic [2:0] colour);
    for (int i = 0; i < 76800; i++) begin
      push_exp(17'(i), colour, (i == 76799), 1'b1);
    end
  endtask

  // Present a plot until accepted; stalls = cycles ready was low.
  task automatic send(input int x, input int y, input int c, input logic clr,
                      input logic [2:0] ccol, output int stalls);
    int  addr;
    logic accepted;
    plot = 1'b1; x_in = 9'(x); y_in = 8'(y); colour_in = 3'(c);
    clear_req = clr; clear_colour = ccol;
    stalls = 0;
    accepted = 1'b0;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clock);
      if (ready) accepted = 1'b1;
      else stalls++;
    end
    if (!accepted) check("plot_accept_timeout", 0, 1);
    if (accepted && x < 320 && y < 240) begin
      addr = y * 320 + x;
      push_exp(17'(addr), 3'(c), 1'b0, 1'b0);
    end
    @(posedge clock);
    #1;
    plot = 1'b0; clear_req = 1'b0;
    $display("plot x=%0d y=%0d c=%0d clear=%0b stalls=%0d", x, y, c, clr, stalls);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge clock) begin
    exp_t e;
    if (resetn) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(mem_addr), 32'h1FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e.addr));
          if (mem_data !== e.data) check("write_data", 32'(mem_data), 32'(e.data));
          if (clear_done !== e.done) check("clear_done_at_write", 32'(clear_done), 32'(e.done));
          if (!e.is_clr) $display("write addr=%0d data=%0d", mem_addr, mem_data);
          if (e.done) $display("clear finished at addr=%0d", mem_addr);
        end
      end else if (clear_done) begin
        check("clear_done_without_write", 32'(clear_done), 0);
      end
    end
  end

  initial begin
    int  st;
    int  cyc;
    logic seen;
    logic injected;

    // Reset values
    #1 resetn = 1'b0;
    wait_cycles(2);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_clear_done", 32'(clear_done), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    resetn = 1'b1;
    wait_cycles(1);

    // Single plot and its latency
    send(10, 2, 5, 1'b0, 3'd0, st);
    check("single_busy_queued", 32'(busy), 1);
    check("single_we_before", 32'(mem_we), 0);
    wait_cycles(1);
    check("single_we_pulse", 32'(mem_we), 1);
    wait_cycles(1);
    check("single_we_off", 32'(mem_we), 0);
    check("single_busy_idle", 32'(busy), 0);

    // Sustained throughput at the far corner
    for (int i = 0; i < 8; i++) begin
      send(319, 239, 7, 1'b0, 3'd0, st);
      check("stream_no_stall", 32'(st), 0);
    end
    wait_cycles(4);
    check("stream_drained", 32'(exp_q.size()), 0);

    // Out-of-range drops and saturation
    send(320, 0, 1, 1'b0, 3'd0, st);
    send(0, 240, 2, 1'b0, 3'd0, st);
    wait_cycles(3);
    check("drop_count_two", 32'(drop_count), 2);
    for (int i = 0; i < 300; i++) send(400 + (i % 100), 0, 3, 1'b0, 3'd0, st);
    wait_cycles(3);
    check("drop_count_saturated", 32'(drop_count), 255);

    // Four plots back to back, clear requested with the fourth
    send(5, 0, 1, 1'b0, 3'd0, st);
    send(6, 0, 2, 1'b0, 3'd0, st);
    send(7, 1, 3, 1'b0, 3'd0, st);
    send(8, 2, 4, 1'b1, 3'd6, st);
    push_clear(3'd6);
    seen = 1'b0;
    injected = 1'b0;
    cyc = 0;
    while (!seen && cyc < 80000) begin
      @(negedge clock);
      cyc++;
      clear_req = 1'b0;
      if (clear_done) begin
        seen = 1'b1;
        check("ready_after_clear", 32'(ready), 1);
      end else begin
        check("ready_low_in_clear", 32'(ready), 0);
        if (mem_we && mem_addr == 17'd100 && !injected) begin
          clear_req = 1'b1; clear_colour = 3'd2; injected = 1'b1;
        end
      end
    end
    clear_req = 1'b0;
    if (!seen) check("clear_done_timeout", 0, 1);
    check("clear_req_injected", 32'(injected), 1);
    wait_cycles(10);
    check("clear_all_written", 32'(exp_q.size()), 0);
    check("clear_busy_idle", 32'(busy), 0);
    check("clear_keeps_drops", 32'(drop_count), 255);
    $display("clear colour=6 complete");

    // Asynchronous reset in the middle of a clear
    clear_req = 1'b1; clear_colour = 3'd4;
    wait_cycles(1);
    clear_req = 1'b0;
    push_clear(3'd4);
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clock);
      if (mem_we && mem_addr == 17'd1000) seen = 1'b1;
    end
    if (!seen) check("midclear_timeout", 0, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_we", 32'(mem_we), 0);
    check("async_rst_ready", 32'(ready), 1);
    check("async_rst_drop", 32'(drop_count), 0);
    exp_q.delete();
    wait_cycles(2);
    resetn = 1'b1;
    $display("reset during clear");
    send(1, 1, 3, 1'b0, 3'd0, st);
    wait_cycles(20);
    check("post_rst_written", 32'(exp_q.size()), 0);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_addr", 32'(mem_addr), 321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
